zero_detect_pipe: RTL and testbench
===================================

// Module: zero_detect_pipe
// PURPOSE
//  Parametrised, pipelined successor to the 2-bit NOR reduction: reduces a WIDTH-bit operand pair
//  to one flag through a FANIN-ary OR tree with a register per tree level, inverted at the end.
//  Feeds the ALU flag logic (zero / equality / all-ones), with a valid/ready handshake and a
//  saturating count of asserted flags for debug/perf.
// PARAMETERS
//  WIDTH   64  operand width, >= 2
//  FANIN   4   OR-tree fan-in per level, >= 2
//  CNT_W   16  width of flag_count
//  LEVELS  derived localparam = ceil(log_FANIN(WIDTH)); also the pipeline depth
// PORTS
//  clk          in   1      clock; all state updates on posedge
//  reset        in   1      synchronous, active-high
//  in_valid     in   1      a/b/mode valid this cycle
//  in_ready     out  1      block accepts input this cycle
//  a            in   WIDTH  operand A
//  b            in   WIDTH  operand B
//  mode         in   2      zd_mode_t: 00 NOR_OR, 01 ZERO_A, 10 EQUAL, 11 ONES_A
//  out_valid    out  1      flag valid
//  out_ready    in   1      consumer accepts flag
//  flag         out  1      result
//  flag_count   out  CNT_W  number of accepted results with flag=1, saturating
//  count_clr    in   1      synchronous clear of flag_count
// BEHAVIOUR
//  - Per-bit prep: NOR_OR p=a|b; ZERO_A p=a; EQUAL p=a^b; ONES_A p=~a. flag = ~|p (all modes).
//  - Tree: level k ORs groups of FANIN bits from level k-1; last group of a level may be partial
//    (missing inputs = 0). Each level is registered with its valid bit.
//  - Global enable en = ~out_valid | out_ready. in_ready = en. Whole pipe shifts when en=1,
//    holds when en=0. Bubbles are not collapsed. Accept = in_valid & in_ready.
//  - Latency: LEVELS cycles from accept to out_valid with out_ready held 1; throughput 1/cycle.
//  - Stall: flag and out_valid stable while out_valid=1 & out_ready=0; no data lost or duplicated.
//  - flag_count increments by 1 on cycles where out_valid & out_ready & flag; saturates at
//    2^CNT_W-1. count_clr has priority over increment (clr and increment same cycle -> 0).
//  - Reset: all stage valids=0, out_valid=0, flag=0, flag_count=0, in_ready=1 next cycle.
//    Reset mid-operation drops all in-flight results; no output handshake for them.
//  - mode sampled only on accept; changing mode with results in flight does not affect them.
//  - WIDTH <= FANIN gives LEVELS=1 (single registered reduction).
// STRUCTURE
//  - Package zd_pkg: typedef enum logic [1:0] zd_mode_t {ZD_NOR_OR, ZD_ZERO_A, ZD_EQUAL, ZD_ONES_A};
//    function clog_fanin(width, fanin) used for LEVELS and per-level widths.
//  - Sub-module or_reduce_stage #(IN_W, FANIN): combinational group-OR, IN_W -> ceil(IN_W/FANIN);
//    instantiated once per level in a generate loop, registers live in the top.
// TESTING
//  1 Legacy: WIDTH=4, NOR_OR, a=0,b=0 -> flag=1; a=4'h2,b=0 -> flag=0; b=4'h8,a=0 -> flag=0.
//  2 Modes, WIDTH=64: ZERO_A a=0 -> 1; EQUAL a=b=64'hDEAD_BEEF -> 1, a^b=64'h1<<63 -> 0;
//    ONES_A a='1 -> 1, a='1 with bit 17 cleared -> 0.
//  3 Latency/throughput: WIDTH=64,FANIN=4 (LEVELS=3), out_ready=1, 10 back-to-back accepts ->
//    first out_valid 3 cycles after first accept, then 10 consecutive valid flags in order.
//  4 Backpressure: out_ready=0 for 5 cycles with pipe full -> in_ready=0, flag/out_valid held;
//    release -> remaining results drain in order, none lost or repeated.
//  5 Counter: CNT_W=2, 5 accepted flag=1 results -> flag_count saturates at 3; count_clr with
//    a simultaneous flag=1 handshake -> flag_count=0.
//  6 Reset mid-stream with 3 in flight -> next cycle out_valid=0, flag=0, flag_count=0, in_ready=1;
//    no stale result appears afterwards. Also WIDTH=5,FANIN=4 partial group, a=5'h10 -> flag=0.

Source files
------------

// File: rtl/zd_pkg.sv
// Shared types and elaboration helpers for the pipelined zero-detect block.
package zd_pkg;

    typedef enum logic [1:0] {
        ZD_NOR_OR = 2'b00,
        ZD_ZERO_A = 2'b01,
        ZD_EQUAL  = 2'b10,
        ZD_ONES_A = 2'b11
    } zd_mode_t;

    // Number of FANIN-ary OR levels needed to reduce width bits to one.
    function automatic int clog_fanin(input int width, input int fanin);
        int n;
        int w;
        n = 0;
        w = width;
        while (w > 1) begin
            w = (w + fanin - 1) / fanin;
            n++;
        end
        return n;
    endfunction

    // Bit count remaining after `level` reduction levels.
    function automatic int level_width(input int width, input int fanin, input int level);
        int w;
        w = width;
        for (int i = 0; i < level; i++) w = (w + fanin - 1) / fanin;
        return w;
    endfunction

endpackage

// File: rtl/or_reduce_stage.sv
// One OR-tree level: each output bit ORs a group of FANIN inputs; the last group may be partial.
module or_reduce_stage #(
    parameter int IN_W  = 8,
    parameter int FANIN = 4
) (
    input  logic [IN_W-1:0]                  in_bits,
    output logic [(IN_W+FANIN-1)/FANIN-1:0]  out_bits
);
    localparam int OUT_W = (IN_W + FANIN - 1) / FANIN;
    localparam int PAD_W = OUT_W * FANIN;

    // Zero-extend so the partial last group ORs in zeros.
    logic [PAD_W-1:0] padded;
    assign padded = PAD_W'(in_bits);

    for (genvar g = 0; g < OUT_W; g++) begin : g_grp
        assign out_bits[g] = |padded[g*FANIN +: FANIN];
    end

endmodule

// File: rtl/zero_detect_pipe.sv
// Pipelined zero/equal/all-ones detector: per-bit prep, registered FANIN-ary OR tree, inverted flag.
module zero_detect_pipe
    import zd_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int FANIN = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             flag,
    output logic [CNT_W-1:0] flag_count,
    input  logic             count_clr
);
    localparam int LEVELS = clog_fanin(WIDTH, FANIN);

    logic             en;
    logic             accept;
    logic [WIDTH-1:0] prep;
    logic [LEVELS:1]  vld_pipe;
    zd_mode_t         mode_t;

    assign mode_t   = zd_mode_t'(mode);
    assign en       = ~out_valid | out_ready;
    assign in_ready = en;
    assign accept   = in_valid & in_ready;

    // Every mode maps onto "flag = no bit of prep set".
    always_comb begin
        prep = a | b;
        case (mode_t)
            ZD_NOR_OR: prep = a | b;
            ZD_ZERO_A: prep = a;
            ZD_EQUAL:  prep = a ^ b;
            ZD_ONES_A: prep = ~a;
            default:   prep = a | b;
        endcase
    end

    for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
        localparam int IN_W  = level_width(WIDTH, FANIN, k - 1);
        localparam int OUT_W = level_width(WIDTH, FANIN, k);

        logic [IN_W-1:0]  d;
        logic [OUT_W-1:0] nxt;
        logic [OUT_W-1:0] q;

        if (k == 1) begin : g_first
            assign d = prep;
        end else begin : g_next
            assign d = g_lvl[k-1].q;
        end

        or_reduce_stage #(.IN_W(IN_W), .FANIN(FANIN)) u_or (
            .in_bits (d),
            .out_bits(nxt)
        );

        // Data needs no reset: it is only observed behind its valid bit.
        always_ff @(posedge clk) begin
            if (en) q <= nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe <= '0;
        end else if (en) begin
            vld_pipe[1] <= accept;
            for (int k = 2; k <= LEVELS; k++) vld_pipe[k] <= vld_pipe[k-1];
        end
    end

    assign out_valid = vld_pipe[LEVELS];
    assign flag      = vld_pipe[LEVELS] & ~g_lvl[LEVELS].q[0];

    always_ff @(posedge clk) begin
        if (reset || count_clr) begin
            flag_count <= '0;
        end else if (out_valid && out_ready && flag && (flag_count != {CNT_W{1'b1}})) begin
            flag_count <= flag_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_zero_detect_pipe.sv
// Directed bench: scoreboard queue of expected flags, checked as results leave the pipe.
module tb_zero_detect_pipe;
    import zd_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready, flag, count_clr;
    logic [63:0] a, b;
    logic [1:0]  mode;
    logic [1:0]  flag_count;

    logic       v4, ir4, ov4, f4;
    logic [3:0] a4, b4;
    logic [1:0] m4;
    logic [15:0] fc4;
    logic       v5, ir5, ov5, f5;
    logic [4:0] a5, b5;
    logic [15:0] fc5;

    always #5 clk = ~clk;

    zero_detect_pipe #(.WIDTH(64), .FANIN(4), .CNT_W(2)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
        .flag(flag), .flag_count(flag_count), .count_clr(count_clr)
    );

    zero_detect_pipe #(.WIDTH(4), .FANIN(4), .CNT_W(16)) u_w4 (
        .clk(clk), .reset(reset), .in_valid(v4), .in_ready(ir4),
        .a(a4), .b(b4), .mode(m4), .out_valid(ov4), .out_ready(1'b1),
        .flag(f4), .flag_count(fc4), .count_clr(1'b0)
    );

    zero_detect_pipe #(.WIDTH(5), .FANIN(4), .CNT_W(16)) u_w5 (
        .clk(clk), .reset(reset), .in_valid(v5), .in_ready(ir5),
        .a(a5), .b(b5), .mode(2'b01), .out_valid(ov5), .out_ready(1'b1),
        .flag(f5), .flag_count(fc5), .count_clr(1'b0)
    );

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   cnt_m = 0;
    int   pops = 0;
    int   pushes = 0;
    int   first_acc = -1;
    int   first_out = -1;
    int   last_pop = -1;
    bit   nxt_exp;
    bit   exp_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic bit ref_flag(input logic [63:0] x, input logic [63:0] y, input logic [1:0] m);
        logic [63:0] p;
        case (m)
            2'b00:   p = x | y;
            2'b01:   p = x;
            2'b10:   p = x ^ y;
            default: p = ~x;
        endcase
        return ~|p;
    endfunction

    // One clock: score the pre-edge handshake, advance, then check the counter.
    task automatic tick();
        bit e;
        bit hs;
        hs = 1'b0;
        e  = 1'b0;
        if (reset) begin
            exp_q.delete();
            cnt_m = 0;
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("stale_out_valid", 64'd1, 64'd0);
                end else begin
                    chk("flag", {63'd0, flag}, {63'd0, exp_q[0]});
                    if (out_ready) begin
                        e = exp_q.pop_front();
                        hs = 1'b1;
                        pops++;
                        last_pop = cyc;
                        if (first_out < 0) first_out = cyc;
                    end
                end
            end
            if (count_clr) cnt_m = 0;
            else if (hs && e && cnt_m != 3) cnt_m++;
            if (in_valid && in_ready) begin
                exp_q.push_back(nxt_exp);
                pushes++;
                if (first_acc < 0) first_acc = cyc;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        chk("flag_count", {62'd0, flag_count}, 64'(cnt_m));
    endtask

    task automatic drive(input logic [63:0] x, input logic [63:0] y, input logic [1:0] m, input bit e);
        a = x; b = y; mode = m; nxt_exp = e; in_valid = 1'b1;
    endtask

    task automatic drain(input int limit);
        for (int i = 0; i < limit && exp_q.size() != 0; i++) tick();
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        logic held;
        logic [63:0] r;
        bit found;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; count_clr = 1'b0;
        a = '0; b = '0; mode = 2'b00; nxt_exp = 1'b0;
        v4 = 1'b0; a4 = '0; b4 = '0; m4 = 2'b00;
        v5 = 1'b0; a5 = '0; b5 = '0;
        @(posedge clk); #1;
        tick(); tick();
        reset = 1'b0;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_flag", {63'd0, flag}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_count", {62'd0, flag_count}, 64'd0);

        // legacy 4-bit NOR, single registered level
        v4 = 1'b1; a4 = 4'h0; b4 = 4'h0; tick();
        chk("w4_valid0", {63'd0, ov4}, 64'd1);
        chk("w4_zero", {63'd0, f4}, 64'd1);
        a4 = 4'h2; b4 = 4'h0; tick();
        chk("w4_a2", {63'd0, f4}, 64'd0);
        a4 = 4'h0; b4 = 4'h8; tick();
        chk("w4_b8", {63'd0, f4}, 64'd0);
        v4 = 1'b0; tick();
        chk("w4_idle", {63'd0, ov4}, 64'd0);

        // partial group: WIDTH=5, FANIN=4, two levels
        v5 = 1'b1; a5 = 5'h00; tick();
        a5 = 5'h10; tick();
        v5 = 1'b0;
        chk("w5_zero", {62'd0, ov5, f5}, 64'd3);
        tick();
        chk("w5_bit4", {62'd0, ov5, f5}, 64'd2);

        // modes on the 64-bit pipe
        drive(64'd0, 64'hFFFF, 2'b01, 1'b1); tick();
        drive(64'hDEAD_BEEF, 64'hDEAD_BEEF, 2'b10, 1'b1); tick();
        drive(64'h1 << 63, 64'd0, 2'b10, 1'b0); tick();
        drive('1, 64'd0, 2'b11, 1'b1); tick();
        drive(~(64'h1 << 17), 64'd0, 2'b11, 1'b0); tick();
        drive(64'd0, 64'd0, 2'b00, 1'b1); tick();
        in_valid = 1'b0;
        drain(10);

        // latency and throughput: 10 back-to-back accepts
        first_acc = -1; first_out = -1; pops = 0;
        for (int i = 0; i < 10; i++) begin
            r = {$urandom, $urandom};
            if (i % 3 == 0) r = '0;
            drive(r, (i % 4 == 2) ? r : 64'(i), 2'(i % 4), 1'b0);
            nxt_exp = ref_flag(a, b, mode);
            tick();
        end
        in_valid = 1'b0;
        drain(10);
        chk("latency", 64'(first_out - first_acc), 64'd3);
        chk("pops", 64'(pops), 64'd10);
        chk("back_to_back", 64'(last_pop - first_out), 64'd9);

        // backpressure with a full pipe
        pushes = 0; pops = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(64'(i % 2), 64'd0, 2'b01, (i % 2) == 0);
            tick();
        end
        in_valid = 1'b0;
        chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
        held = flag;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_valid", {63'd0, out_valid}, 64'd1);
            chk("bp_hold_flag", {63'd0, flag}, {63'd0, held});
        end
        out_ready = 1'b1;
        drain(10);
        chk("bp_no_loss", 64'(pops), 64'(pushes));

        // saturating counter, then clear racing a flag=1 handshake
        for (int i = 0; i < 5; i++) begin
            drive(64'd0, 64'd0, 2'b01, 1'b1); tick();
        end
        in_valid = 1'b0;
        drain(10);
        chk("cnt_sat", {62'd0, flag_count}, 64'd3);
        drive(64'd0, 64'd0, 2'b01, 1'b1); tick();
        in_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (out_valid) found = 1'b1;
            else tick();
        end
        chk("clr_found_valid", {63'd0, found}, 64'd1);
        count_clr = 1'b1; tick(); count_clr = 1'b0;
        chk("cnt_clr_prio", {62'd0, flag_count}, 64'd0);

        // reset with three results in flight
        drive(64'd0, 64'd0, 2'b00, 1'b1); tick();
        drive(64'd0, 64'd0, 2'b00, 1'b1); tick();
        drive(64'd0, 64'd0, 2'b00, 1'b1); tick();
        in_valid = 1'b0;
        reset = 1'b1; tick(); reset = 1'b0;
        chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_flag", {63'd0, flag}, 64'd0);
        chk("mid_rst_count", {62'd0, flag_count}, 64'd0);
        chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
        for (int i = 0; i < 6; i++) tick();
        chk("no_stale", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
